// File: rtl/seq_arith_pkg.sv
// Shared constants and state encoding for the multi-cycle arithmetic blocks.
package seq_arith_pkg;

  localparam int unsigned SEQ_WIDTH      = 64;
  localparam int unsigned SEQ_CHUNK      = 16;
  localparam int unsigned SEQ_NUM_CHUNKS = SEQ_WIDTH / SEQ_CHUNK;
  localparam int unsigned SEQ_IDX_W      = $clog2(SEQ_NUM_CHUNKS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/cla_slice.sv
// Combinational CHUNK-bit carry-lookahead adder built from 4-bit lookahead groups.
// CHUNK must be a multiple of 4; group carries ripple from one group to the next.
module cla_slice #(
  parameter int unsigned CHUNK = 16
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  localparam int unsigned NumGroups = CHUNK / 4;

  logic [CHUNK-1:0] g;
  logic [CHUNK-1:0] p;
  logic [CHUNK:0]   c;
  logic             term;
  logic             acc;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry inside a group is a flat sum-of-products of the group's g/p and its carry-in.
  always_comb begin
    c    = '0;
    c[0] = cin;
    term = 1'b0;
    acc  = 1'b0;
    for (int gi = 0; gi < int'(NumGroups); gi++) begin
      for (int k = 0; k < 4; k++) begin
        acc = c[gi*4];
        for (int m = 0; m <= k; m++) begin
          acc = acc & p[gi*4+m];
        end
        for (int j = 0; j <= k; j++) begin
          term = g[gi*4+j];
          for (int m = j + 1; m <= k; m++) begin
            term = term & p[gi*4+m];
          end
          acc = acc | term;
        end
        c[gi*4+k+1] = acc;
      end
    end
  end

  assign s    = p ^ c[CHUNK-1:0];
  assign cout = c[CHUNK];

endmodule

// File: rtl/seq_cla_subtractor.sv
// Multi-cycle subtractor: diff = A - B - bin, one CHUNK-bit slice per cycle through a
// single shared CLA slice, computed as A + ~B + ~bin with the carry held between cycles.
module seq_cla_subtractor
  import seq_arith_pkg::*;
#(
  parameter int unsigned WIDTH = SEQ_WIDTH,
  parameter int unsigned CHUNK = SEQ_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int unsigned NumChunks = WIDTH / CHUNK;
  localparam int unsigned IdxW      = (NumChunks > 1) ? $clog2(NumChunks) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumChunks - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] nb_q, nb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             carry_q, carry_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;
  logic [IdxW-1:0]  idx_q, idx_d;

  logic [CHUNK-1:0] slice_a;
  logic [CHUNK-1:0] slice_b;
  logic [CHUNK-1:0] slice_s;
  logic             slice_cout;
  logic             accept;

  assign in_ready  = !rst && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;

  assign slice_a = a_q[32'(idx_q) * CHUNK +: CHUNK];
  assign slice_b = nb_q[32'(idx_q) * CHUNK +: CHUNK];

  cla_slice #(
    .CHUNK(CHUNK)
  ) u_cla_slice (
    .a   (slice_a),
    .b   (slice_b),
    .cin (carry_q),
    .s   (slice_s),
    .cout(slice_cout)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    nb_d    = nb_q;
    diff_d  = diff_q;
    carry_d = carry_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    idx_d   = idx_q;

    unique case (state_q)
      IDLE: state_d = IDLE;
      BUSY: begin
        diff_d[32'(idx_q) * CHUNK +: CHUNK] = slice_s;
        carry_d = slice_cout;
        idx_d   = idx_q + IdxW'(1);
        if (idx_q == LastIdx) begin
          state_d = DONE;
          bout_d  = ~slice_cout;
          // Operand signs differ exactly when A's MSB equals the MSB of ~B.
          ovf_d   = (a_q[WIDTH-1] == nb_q[WIDTH-1]) && (slice_s[CHUNK-1] != a_q[WIDTH-1]);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Covers both a fresh accept from IDLE and an accept overlapping the output handshake.
    if (accept) begin
      state_d = BUSY;
      a_d     = A;
      nb_d    = ~B;
      carry_d = ~bin;
      idx_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      nb_q    <= '0;
      diff_q  <= '0;
      carry_q <= 1'b0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      nb_q    <= nb_d;
      diff_q  <= diff_d;
      carry_q <= carry_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: tb/tb_seq_cla_subtractor.sv
// Self-checking bench for seq_cla_subtractor: scoreboard of expected results, one task per scenario.
module tb_seq_cla_subtractor;

  localparam int unsigned W = 64;
  localparam int MaxWait = 20;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;

  always #5 clk = ~clk;

  seq_cla_subtractor dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (a),
    .B        (b),
    .bin      (bin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .diff     (diff),
    .bout     (bout),
    .ovf      (ovf)
  );

  typedef struct packed {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } exp_t;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } vec_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
    logic [W:0] r;
    exp_t e;
    r      = {1'b0, av} - {1'b0, bv} - {{W{1'b0}}, bi};
    e.diff = r[W-1:0];
    e.bout = r[W];
    e.ovf  = (av[W-1] != bv[W-1]) && (r[W-1] != av[W-1]);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds in_valid over one edge (caller ensures in_ready) and queues the expected result.
  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi,
                      input exp_t e);
    a        = av;
    b        = bv;
    bin      = bi;
    in_valid = 1'b1;
    sb.push_back(e);
    tick();
    in_valid = 1'b0;
    a        = $urandom();
    b        = $urandom();
  endtask

  // Returns edges elapsed until out_valid is seen, capped at MaxWait.
  task automatic wait_out(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < MaxWait) begin
      tick();
      cycles++;
    end
  endtask

  task automatic test_reset();
    exp_t z;
    z        = '0;
    rst      = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    tick();
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready);
    end
    n_checks++;
    if ({diff, bout, ovf, out_valid} !== {z, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got diff=%h bout=%b ovf=%b ov=%b want 0", diff, bout, ovf,
               out_valid);
    end
    in_valid = 1'b0;
    rst      = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_directed();
    vec_t vt[5];
    exp_t e;
    exp_t got;
    int   cyc;
    vt[0] = '{64'd100, 64'd30, 1'b0, 64'd70, 1'b0, 1'b0};
    vt[1] = '{64'd0, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
    vt[2] = '{64'h8000_0000_0000_0000, 64'd1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1};
    vt[3] = '{64'h0001_0000_0000_0000, 64'd0, 1'b1, 64'h0000_FFFF_FFFF_FFFF, 1'b0, 1'b0};
    vt[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'd0, 1'b0, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (in_ready !== 1'b1) begin
        n_fail++; $display("FAIL dir%0d_in_ready: got %b want 1", i, in_ready);
      end
      send(vt[i].a, vt[i].b, vt[i].bin, '{vt[i].diff, vt[i].bout, vt[i].ovf});
      wait_out(cyc);
      n_checks++;
      if (cyc !== 4) begin
        n_fail++; $display("FAIL dir%0d_latency: got %0d want 4", i, cyc);
      end
      e   = sb.pop_front();
      got = '{diff, bout, ovf};
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL dir%0d_result: got diff=%h bout=%b ovf=%b want diff=%h bout=%b ovf=%b",
                 i, got.diff, got.bout, got.ovf, e.diff, e.bout, e.ovf);
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++; $display("FAIL dir%0d_pulse_width: got out_valid=%b want 0", i, out_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] av;
    logic [W-1:0] bv;
    logic         bi;
    exp_t         e;
    exp_t         got;
    int           cyc;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      av = {$urandom(), $urandom()};
      bv = {$urandom(), $urandom()};
      bi = 1'($urandom_range(0, 1));
      if (i == 0) bv = av;
      n_checks++;
      if (in_ready !== 1'b1) begin
        n_fail++; $display("FAIL b2b%0d_in_ready: got %b want 1", i, in_ready);
      end
      send(av, bv, bi, model(av, bv, bi));
      wait_out(cyc);
      n_checks++;
      if (cyc !== 4) begin
        n_fail++; $display("FAIL b2b%0d_latency: got %0d want 4", i, cyc);
      end
      e   = sb.pop_front();
      got = '{diff, bout, ovf};
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL b2b%0d_result: got diff=%h bout=%b ovf=%b want diff=%h bout=%b ovf=%b",
                 i, got.diff, got.bout, got.ovf, e.diff, e.bout, e.ovf);
      end
    end
    tick();
  endtask

  task automatic test_backpressure();
    exp_t e;
    exp_t got;
    int   cyc;
    out_ready = 1'b0;
    send(64'd50, 64'd20, 1'b0, '{64'd30, 1'b0, 1'b0});
    wait_out(cyc);
    n_checks++;
    if (cyc !== 4) begin
      n_fail++; $display("FAIL bp_latency: got %0d want 4", cyc);
    end
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if ({out_valid, in_ready, diff} !== {1'b1, 1'b0, 64'd30}) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got ov=%b ir=%b diff=%h want ov=1 ir=0 diff=1e", k, out_valid,
                 in_ready, diff);
      end
      if (k < 2) tick();
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_release_in_ready: got %b want 1", in_ready);
    end
    e   = sb.pop_front();
    got = '{diff, bout, ovf};
    n_checks++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL bp_result: got diff=%h bout=%b ovf=%b want diff=%h bout=%b ovf=%b",
               got.diff, got.bout, got.ovf, e.diff, e.bout, e.ovf);
    end
    send(64'd7, 64'd9, 1'b0, '{64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0});
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_handoff_out_valid: got %b want 0", out_valid);
    end
    wait_out(cyc);
    n_checks++;
    if (cyc !== 4) begin
      n_fail++; $display("FAIL bp_second_latency: got %0d want 4", cyc);
    end
    e   = sb.pop_front();
    got = '{diff, bout, ovf};
    n_checks++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL bp_second_result: got diff=%h bout=%b ovf=%b want diff=%h bout=%b ovf=%b",
               got.diff, got.bout, got.ovf, e.diff, e.bout, e.ovf);
    end
    tick();
  endtask

  task automatic test_reset_midop();
    exp_t e;
    exp_t got;
    int   cyc;
    int   pulses;
    out_ready = 1'b1;
    send(64'd1000, 64'd1, 1'b0, model(64'd1000, 64'd1, 1'b0));
    tick();
    rst = 1'b1;
    tick();
    n_checks++;
    if ({out_valid, in_ready, diff, bout, ovf} !== {1'b0, 1'b0, 64'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL midrst_outputs: got ov=%b ir=%b diff=%h bout=%b ovf=%b want all 0",
               out_valid, in_ready, diff, bout, ovf);
    end
    tick();
    rst = 1'b0;
    sb.delete();
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL midrst_in_ready: got %b want 1", in_ready);
    end
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      if (out_valid) pulses++;
      tick();
    end
    n_checks++;
    if (pulses !== 0) begin
      n_fail++; $display("FAIL midrst_no_pulse: got %0d out_valid cycles want 0", pulses);
    end
    send(64'd5, 64'd3, 1'b0, '{64'd2, 1'b0, 1'b0});
    wait_out(cyc);
    n_checks++;
    if (cyc !== 4) begin
      n_fail++; $display("FAIL midrst_latency: got %0d want 4", cyc);
    end
    e   = sb.pop_front();
    got = '{diff, bout, ovf};
    n_checks++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL midrst_result: got diff=%h bout=%b ovf=%b want diff=%h bout=%b ovf=%b",
               got.diff, got.bout, got.ovf, e.diff, e.bout, e.ovf);
    end
    tick();
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    bin       = 1'b0;
    out_ready = 1'b1;
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
